// File: rtl/llc_port_arbiter_pkg.sv
// Shared types and helpers for the lower-level cache port arbiter.
package cache_arb_pkg;

  localparam int DEF_B         = 64;
  localparam int DEF_ADDR_BITS = 64;

  typedef logic [DEF_B*8-1:0]       line_t;
  typedef logic [DEF_ADDR_BITS-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP,
    RETURN
  } arb_state_t;

  function automatic addr_t line_addr(input addr_t a, input int unsigned bytes);
    return a & ~addr_t'(bytes - 1);
  endfunction

endpackage

// File: rtl/llc_port_arbiter_if.sv
// Request/response/lower-level bundle between the requesters, the arbiter and the lower cache.
interface llc_port_arbiter_if #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_BITS = 64,
  parameter int LINE_BITS = 512
);
  logic [NUM_REQ-1:0]           req_valid_in;
  logic [NUM_REQ-1:0]           req_ready_out;
  logic [NUM_REQ-1:0]           req_we_in;
  logic [NUM_REQ*ADDR_BITS-1:0] req_addr_in;
  logic [NUM_REQ*LINE_BITS-1:0] req_line_in;
  logic [NUM_REQ-1:0]           resp_valid_out;
  logic [NUM_REQ-1:0]           resp_ready_in;
  logic [ADDR_BITS-1:0]         resp_addr_out;
  logic [LINE_BITS-1:0]         resp_line_out;
  logic                         lc_valid_out;
  logic                         lc_ready_in;
  logic                         lc_we_out;
  logic [ADDR_BITS-1:0]         lc_addr_out;
  logic [LINE_BITS-1:0]         lc_value_out;
  logic                         lc_valid_in;
  logic                         lc_ready_out;
  logic [ADDR_BITS-1:0]         lc_addr_in;
  logic [LINE_BITS-1:0]         lc_value_in;

  modport master (
    output req_valid_in, req_we_in, req_addr_in, req_line_in, resp_ready_in,
           lc_ready_in, lc_valid_in, lc_addr_in, lc_value_in,
    input  req_ready_out, resp_valid_out, resp_addr_out, resp_line_out,
           lc_valid_out, lc_we_out, lc_addr_out, lc_value_out, lc_ready_out
  );

  modport slave (
    input  req_valid_in, req_we_in, req_addr_in, req_line_in, resp_ready_in,
           lc_ready_in, lc_valid_in, lc_addr_in, lc_value_in,
    output req_ready_out, resp_valid_out, resp_addr_out, resp_line_out,
           lc_valid_out, lc_we_out, lc_addr_out, lc_value_out, lc_ready_out
  );
endinterface

// File: rtl/llc_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after 'last' in cyclic order wins.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  // Scan farthest-first so the nearest requester after 'last' overwrites the result.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int k = N; k >= 1; k--) begin
      int j;
      j = (int'(last) + k) % N;
      if (req[IW'(j)]) begin
        gnt          = '0;
        gnt[IW'(j)]  = 1'b1;
        gnt_idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/llc_port_arbiter.sv
// Shares one lower-level cache port among NUM_REQ requesters, one transaction in flight,
// with read re-issue on timeout and saturating drop/retry counters.
//
//   state     | meaning
//   IDLE      | offer round-robin grant, latch winner's request
//   ISSUE     | present request to lower level until accepted
//   WAIT_RESP | accept returned lines, match address, time out to re-issue
//   RETURN    | hand matched line back to the granted requester
module llc_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int B              = DEF_B,
  parameter int ADDR_BITS      = DEF_ADDR_BITS,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_BITS       = 8
) (
  input  logic                clk_in,
  input  logic                rst_in,
  llc_port_arbiter_if.slave   bus,
  output logic [CNT_BITS-1:0] drop_cnt_out,
  output logic [CNT_BITS-1:0] retry_cnt_out
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int LW = B * 8;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t          r_state;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [IW-1:0]       r_gnt_idx;
  logic [IW-1:0]       r_last;
  logic                r_we;
  logic [ADDR_BITS-1:0] r_addr;
  logic [LW-1:0]       r_line;
  logic [LW-1:0]       r_resp_line;
  logic [TW-1:0]       r_timer;
  logic [CNT_BITS-1:0] r_drop;
  logic [CNT_BITS-1:0] r_retry;

  logic [NUM_REQ-1:0]   w_req_gnt;
  logic [IW-1:0]        w_gnt_idx;
  logic [ADDR_BITS-1:0] w_req_addr [NUM_REQ];
  logic [LW-1:0]        w_req_line [NUM_REQ];
  logic                 w_match;
  logic                 w_timeout;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_req_addr[g] = bus.req_addr_in[g*ADDR_BITS +: ADDR_BITS];
    assign w_req_line[g] = bus.req_line_in[g*LW +: LW];
  end

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req     (bus.req_valid_in),
    .last    (r_last),
    .gnt     (w_req_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign w_match   = bus.lc_valid_in && (line_addr(bus.lc_addr_in, B) == r_addr);
  assign w_timeout = (r_timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_last      <= IW'(NUM_REQ - 1);
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_line      <= '0;
      r_resp_line <= '0;
      r_timer     <= '0;
      r_drop      <= '0;
      r_retry     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_req_gnt) begin
            r_gnt     <= w_req_gnt;
            r_gnt_idx <= w_gnt_idx;
            r_last    <= w_gnt_idx;
            r_we      <= bus.req_we_in[w_gnt_idx];
            r_addr    <= line_addr(w_req_addr[w_gnt_idx], B);
            r_line    <= w_req_line[w_gnt_idx];
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.lc_ready_in) begin
            r_timer <= '0;
            r_state <= r_we ? IDLE : WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          // A match beats a coincident timeout, so no retry is counted then.
          if (w_match) begin
            r_resp_line <= bus.lc_value_in;
            r_state     <= RETURN;
          end else begin
            if (bus.lc_valid_in && (r_drop != '1))
              r_drop <= r_drop + 1'b1;
            if (w_timeout) begin
              if (r_retry != '1)
                r_retry <= r_retry + 1'b1;
              r_state <= ISSUE;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
        end
        RETURN: begin
          if (bus.resp_ready_in[r_gnt_idx])
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_out  = (r_state == IDLE) ? w_req_gnt : '0;
  assign bus.lc_valid_out   = (r_state == ISSUE);
  assign bus.lc_we_out      = (r_state == ISSUE) && r_we;
  assign bus.lc_addr_out    = (r_state == ISSUE) ? r_addr : '0;
  assign bus.lc_value_out   = ((r_state == ISSUE) && r_we) ? r_line : '0;
  assign bus.lc_ready_out   = (r_state == WAIT_RESP);
  assign bus.resp_valid_out = (r_state == RETURN) ? r_gnt : '0;
  assign bus.resp_addr_out  = (r_state == RETURN) ? r_addr : '0;
  assign bus.resp_line_out  = (r_state == RETURN) ? r_resp_line : '0;
  assign drop_cnt_out       = r_drop;
  assign retry_cnt_out      = r_retry;

endmodule
